// File: rtl/score_collector_if.sv
// score_collector_if
//   Bundles the serial logit input stream and the packed frame output of
//   score_collector.
//   Input side : in_valid, in_ready, in_data[DATA_WIDTH], in_last
//   Output side: out_valid, out_ready, out_data[NUM_CLASSES*DATA_WIDTH],
//                frame_err, nan_flag
//   modport slave  : the collector's view
//   modport master : the environment's view (producer + consumer)
interface score_collector_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32
);
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] out_data;
  logic                              frame_err;
  logic                              nan_flag;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_err, nan_flag
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_err, nan_flag
  );
endinterface

// File: rtl/score_collector.sv
// score_collector
//   Packs NUM_CLASSES serial fp32 logits (class 0 first) into one wide
//   vector with class 0 in the most-significant slice. A separate output
//   register holds the finished frame while the next frame fills.
//   Ports:
//     clk   : clock, all state on rising edge
//     rst_n : asynchronous active-low reset
//     bus   : score_collector_if.slave (input stream, packed output,
//             frame_err pulse, nan_flag)
//   Optional feature: define SCORE_COLLECT_NAN_CHECK_EN to build NaN
//   detection; otherwise nan_flag is tied low.
module score_collector #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  score_collector_if.slave  bus
);
  localparam int CNT_W  = $clog2(NUM_CLASSES);
  localparam int FILL_W = (NUM_CLASSES-1)*DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CLASSES-1);

  logic [CNT_W-1:0]  cnt;
  logic [FILL_W-1:0] fill;
  logic              at_last;
  logic              accept;
  logic              complete;

  assign at_last  = (cnt == CNT_LAST);
  // Only the completing word can stall: it needs the output register free.
  assign bus.in_ready = !(at_last && bus.out_valid && !bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign complete = accept && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      fill          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;

      if (complete) begin
        bus.out_data  <= {fill, bus.in_data};
        bus.out_valid <= 1'b1;
        cnt           <= '0;
        // Frame still emitted when in_last is missing; just flag it.
        bus.frame_err <= !bus.in_last;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (accept && !complete) begin
        if (bus.in_last) begin
          // Early in_last: drop the partial frame, output untouched.
          cnt           <= '0;
          fill          <= '0;
          bus.frame_err <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          fill <= {fill[FILL_W-DATA_WIDTH-1:0], bus.in_data};
        end
      end
    end
  end

`ifdef SCORE_COLLECT_NAN_CHECK_EN
  // IEEE-754 single NaN: exponent all ones, mantissa non-zero.
  logic word_nan;
  logic nan_acc;

  assign word_nan = (&bus.in_data[30:23]) && (|bus.in_data[22:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_acc      <= 1'b0;
      bus.nan_flag <= 1'b0;
    end else if (complete) begin
      bus.nan_flag <= nan_acc || word_nan;
      nan_acc      <= 1'b0;
    end else if (accept) begin
      nan_acc <= bus.in_last ? 1'b0 : (nan_acc || word_nan);
    end
  end
`else
  assign bus.nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_score_collector.sv
module tb_score_collector;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int OW = N*W;

`ifdef SCORE_COLLECT_NAN_CHECK_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_collector_if #(.NUM_CLASSES(N), .DATA_WIDTH(W)) bus();

  score_collector #(.NUM_CLASSES(N), .DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: the frame being assembled as a list of words, plus
  // the frame currently presented to the consumer.
  logic [W-1:0]  cur[$];
  logic          m_valid;
  logic [OW-1:0] m_data;
  logic          m_nan;
  logic          m_err;
  logic          prev_ov;
  int            rise_cyc[$];

  logic          cur_v, cur_l, cur_r;
  logic [W-1:0]  cur_d;

  task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit is_nan(input logic [W-1:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  function automatic logic m_ready();
    return !((cur.size() == N-1) && m_valid && !cur_r);
  endfunction

  task automatic model_reset();
    cur.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_nan   = 1'b0;
    m_err   = 1'b0;
  endtask

  // Apply inputs (just after a rising edge) and move to the falling edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    cur_v = v; cur_d = d; cur_l = l; cur_r = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("in_ready",  {{(OW-1){1'b0}}, bus.in_ready},  {{(OW-1){1'b0}}, m_ready()});
    chk("out_valid", {{(OW-1){1'b0}}, bus.out_valid}, {{(OW-1){1'b0}}, m_valid});
    chk("frame_err", {{(OW-1){1'b0}}, bus.frame_err}, {{(OW-1){1'b0}}, m_err});
    chk("out_data",  bus.out_data, m_data);
    chk("nan_flag",  {{(OW-1){1'b0}}, bus.nan_flag},  {{(OW-1){1'b0}}, m_nan});
    if (bus.out_valid && !prev_ov) rise_cyc.push_back(cyc);
    prev_ov = bus.out_valid;
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic step();
    logic acc, done, err, anynan;
    acc  = cur_v && m_ready();
    done = 1'b0;
    err  = 1'b0;
    if (acc) begin
      cur.push_back(cur_d);
      if (cur.size() == N) begin
        done   = 1'b1;
        anynan = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_data[(N-1-i)*W +: W] = cur[i];
          if (is_nan(cur[i])) anynan = 1'b1;
        end
        m_nan   = NAN_EN && anynan;
        m_valid = 1'b1;
        err     = !cur_l;
        cur.delete();
      end else if (cur_l) begin
        err = 1'b1;
        cur.delete();
      end
    end
    if (!done && m_valid && cur_r) m_valid = 1'b0;
    m_err = err;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    drive(v, d, l, r);
    check_model();
    step();
  endtask

  task automatic send_frame(input logic [15:0] tag, input logic r);
    for (int i = 0; i < N; i++)
      cycle(1'b1, {tag, 16'(i)}, (i == N-1), r);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic         r;
    logic         e_rdy;
    logic         e_ov;
    logic         e_err;
    logic         chk_data;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic l,
                              input logic e_ov, input logic e_err, input logic cd);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = 1'b1;
    t.e_rdy = 1'b1; t.e_ov = e_ov; t.e_err = e_err; t.chk_data = cd;
    t.e_hi = 32'h3F80_0000; t.e_lo = 32'h4000_0000;
    return t;
  endfunction

  vec_t vecs[18];

  initial begin
    logic [W-1:0] w;
    logic         v, l, r;
    int           base;

    for (int i = 0; i < 9; i++) vecs[i] = mk(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) vecs[12+i] = mk(1'b1, 32'(i+100), (i == 3), 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[17] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    cur_v = 1'b0; cur_d = '0; cur_l = 1'b0; cur_r = 1'b0;
    prev_ov = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {{(OW-1){1'b0}}, bus.out_valid}, '0);
    chk("rst_out_data",  bus.out_data, '0);
    chk("rst_frame_err", {{(OW-1){1'b0}}, bus.frame_err}, '0);
    chk("rst_nan_flag",  {{(OW-1){1'b0}}, bus.nan_flag}, '0);
    chk("rst_in_ready",  {{(OW-1){1'b0}}, bus.in_ready}, {{(OW-1){1'b0}}, 1'b1});
    rst_n = 1'b1;

    // Table: basic frame, then early in_last on word 4
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      chk($sformatf("vec%0d_in_ready", i),  {{(OW-1){1'b0}}, bus.in_ready},  {{(OW-1){1'b0}}, vecs[i].e_rdy});
      chk($sformatf("vec%0d_out_valid", i), {{(OW-1){1'b0}}, bus.out_valid}, {{(OW-1){1'b0}}, vecs[i].e_ov});
      chk($sformatf("vec%0d_frame_err", i), {{(OW-1){1'b0}}, bus.frame_err}, {{(OW-1){1'b0}}, vecs[i].e_err});
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d_hi", i), {{(OW-W){1'b0}}, bus.out_data[OW-1 -: W]}, {{(OW-W){1'b0}}, vecs[i].e_hi});
        chk($sformatf("vec%0d_lo", i), {{(OW-W){1'b0}}, bus.out_data[W-1:0]},    {{(OW-W){1'b0}}, vecs[i].e_lo});
      end
      check_model();
      step();
    end

    // After the abort, the next 10 words form a correct frame
    send_frame(16'hA0A0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("post_abort_top", {{(OW-W){1'b0}}, bus.out_data[OW-1 -: W]}, {{(OW-W){1'b0}}, 32'hA0A0_0000});
    check_model(); step();
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back frames with out_ready held high
    rise_cyc.delete();
    base = cyc;
    send_frame(16'hB001, 1'b1);
    send_frame(16'hB002, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("b2b_rises", OW'(rise_cyc.size()), OW'(2));
    if (rise_cyc.size() == 2)
      chk("b2b_spacing", OW'(rise_cyc[1] - rise_cyc[0]), OW'(N));

    // Stall: frame 2 fills while frame 1 is held
    send_frame(16'hC001, 1'b1);
    for (int i = 0; i < N-1; i++) cycle(1'b1, {16'hC002, 16'(i)}, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, {16'hC002, 16'(N-1)}, 1'b1, 1'b0);
      chk("stall_in_ready", {{(OW-1){1'b0}}, bus.in_ready}, '0);
      chk("stall_hold_top", {{(OW-W){1'b0}}, bus.out_data[OW-1 -: W]}, {{(OW-W){1'b0}}, 32'hC001_0000});
      check_model(); step();
    end
    drive(1'b1, {16'hC002, 16'(N-1)}, 1'b1, 1'b1);
    chk("release_in_ready", {{(OW-1){1'b0}}, bus.in_ready}, {{(OW-1){1'b0}}, 1'b1});
    check_model(); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("swap_out_valid", {{(OW-1){1'b0}}, bus.out_valid}, {{(OW-1){1'b0}}, 1'b1});
    chk("swap_top", {{(OW-W){1'b0}}, bus.out_data[OW-1 -: W]}, {{(OW-W){1'b0}}, 32'hC002_0000});
    check_model(); step();
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // NaN on word 5, then a clean frame
    for (int i = 0; i < N; i++)
      cycle(1'b1, (i == 5) ? 32'h7FC0_0000 : 32'h3F80_0000, (i == N-1), 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("nan_frame", {{(OW-1){1'b0}}, bus.nan_flag}, {{(OW-1){1'b0}}, NAN_EN});
    check_model(); step();
    send_frame(16'h3F80, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("clean_frame_nan", {{(OW-1){1'b0}}, bus.nan_flag}, '0);
    check_model(); step();

    // Async reset mid-frame with a held output
    send_frame(16'hD001, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, {16'hD002, 16'(i)}, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", {{(OW-1){1'b0}}, bus.out_valid}, '0);
    chk("arst_out_data",  bus.out_data, '0);
    chk("arst_frame_err", {{(OW-1){1'b0}}, bus.frame_err}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_ov = 1'b0;
    send_frame(16'hE001, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("post_rst_top", {{(OW-W){1'b0}}, bus.out_data[OW-1 -: W]}, {{(OW-W){1'b0}}, 32'hE001_0000});
    check_model(); step();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      if (cur.size() == N-1) l = ($urandom_range(0, 9) != 0);
      else                   l = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 15))
        0, 1:    w = {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
        2:       w = 32'h7F80_0000;
        default: w = $urandom;
      endcase
      cycle(v, w, l, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/score_collector.md
# score_collector

Final-stage packer between the last fully-connected layer and the argmax comparator tree. Accepts the classifier's fp32 logits serially, one per handshake, in class order 0..NUM_CLASSES-1, and presents them as one wide vector with class 0 in the most-significant word. This matches the comparator tree's lane mapping (bits [31:0] = class 9, bits [319:288] = class 0). A separate output register lets the next frame fill while the current frame waits for the consumer.

## Interface
- NUM_CLASSES, 10, logits per frame.
- DATA_WIDTH, 32, width of one logit (IEEE-754 single).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  logit word valid.
- in_ready  out  1  collector can accept a word this cycle.
- in_data  in  DATA_WIDTH  logit, class order 0 first.
- in_last  in  1  marks the final word of a frame.
- out_valid  out  1  packed frame available (registered level).
- out_ready  in  1  consumer takes the frame.
- out_data  out  NUM_CLASSES*DATA_WIDTH  packed frame; first-arrived word in the top slice.
- frame_err  out  1  one-cycle pulse on framing error.
- nan_flag  out  1  frame contains a NaN; qualified by out_valid.

## Operation
- Input accept: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Fill register shifts left by DATA_WIDTH on each accept, with the new word in the low slice. Word counter cnt runs 0..NUM_CLASSES-1.
- The accept with cnt==NUM_CLASSES-1 is the frame-complete event:
  - out_data <= {fill[(NUM_CLASSES-1)*DATA_WIDTH-1:0], in_data}
  - out_valid <= 1; cnt <= 0
- in_ready = !(cnt==NUM_CLASSES-1 && out_valid && !out_ready). Only the completing word stalls. Words 0..NUM_CLASSES-2 are always accepted.
- Output handshake clears out_valid next cycle unless a frame-complete event occurs in the same cycle. If it does, out_valid stays 1 and out_data takes the new frame.
- out_data and nan_flag hold stable while out_valid=1 and out_ready=0.
- Early in_last (accepted with cnt<NUM_CLASSES-1):
  - frame_err pulses next cycle; cnt <= 0; the partial frame is discarded.
  - out_valid and out_data are unaffected.
- Missing in_last on the completing word: the frame is still emitted and frame_err pulses next cycle.
- Reset values: out_valid=0, out_data=0, frame_err=0, nan_flag=0, cnt=0, fill=0. in_ready=1 immediately after reset.

## Timing
- Latency: out_valid rises on the cycle after the completing word is accepted.
- Throughput: one word per cycle sustained when out_ready is held high, i.e. one frame per NUM_CLASSES cycles.
- The downstream comparator samples on the rising edge of valid. With out_ready=1, out_valid is low for at least NUM_CLASSES-1 cycles between consecutive frames, which guarantees a rising edge per frame.
- in_ready is combinational from out_ready (single-cycle path). All other outputs are registered.
- Async reset asserted mid-frame discards the partial frame and any held output, with no frame_err. After deassertion the first accepted word is class 0.

## Configuration
- SCORE_COLLECT_NAN_CHECK_EN defined:
  - A word is NaN if exponent == all ones and mantissa != 0.
  - A sticky per-frame bit ORs the NaN check across all words and is copied to nan_flag together with out_data on frame completion.
  - The sticky bit clears on frame completion, on early-in_last abort, and on reset.
- Not defined: nan_flag is tied to 0 and no detection logic is built.

## Test plan
- Frame of 0x3F800000 (1.0) x9, then 0x40000000 on class 9 with in_last, out_ready=1 → out_valid pulses 1 cycle after word 10; out_data[31:0]=0x40000000, out_data[319:288]=0x3F800000; frame_err=0.
- Two back-to-back frames, out_ready=1, in_valid held high → 20 accepts in 20 cycles; two out_valid pulses 10 cycles apart, each followed by out_valid low.
- out_ready=0 while frame 2 fills → in_ready drops only at the frame-2 completing word. Frame 1 holds stable. Raising out_ready delivers frame 1 and loads frame 2 in the same cycle; out_valid stays 1.
- in_last on word 4 (cnt=3) → frame_err pulse, no out_valid; the next 10 words form a correct frame.
- Word 5 = 0x7FC00000 with SCORE_COLLECT_NAN_CHECK_EN → nan_flag=1 for that frame and 0 for the following clean frame. Without the macro, nan_flag=0.
- rst_n low at word 6, then a full frame → only the post-reset frame is emitted, with class 0 in the top slice.
